folded_threshold_unit: RTL and testbench

//  Sequential, parametrised successor to the combinational MAJ-N gate.

---
 rtl/folded_threshold_unit_if.sv | 27 ++
 rtl/folded_threshold_unit.sv | 129 ++++++++++++
 tb/tb_folded_threshold_unit.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/folded_threshold_unit_if.sv
// Handshake bundle between the vote-vector source, the folded threshold unit
// and the decision consumer. The source/consumer side uses master, the unit uses slave.
interface folded_threshold_unit_if #(
  parameter int N  = 31,
  parameter int CW = $clog2(N + 1)
);
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  x;
  logic          thr_mode;
  logic [CW-1:0] thr;
  logic          out_valid;
  logic          out_ready;
  logic          y;
  logic [CW-1:0] hw;
  logic          early;

  modport master (
    output in_valid, x, thr_mode, thr, out_ready,
    input  in_ready, out_valid, y, hw, early
  );

  modport slave (
    input  in_valid, x, thr_mode, thr, out_ready,
    output in_ready, out_valid, y, hw, early
  );
endinterface

// File: rtl/folded_threshold_unit.sv
// Folded threshold gate: counts the ones of an N-bit vote vector FOLD_W bits per
// cycle and reports y = (count >= T) together with the count. T is either the
// strict majority floor(N/2)+1 or a programmable threshold. With EARLY_EXIT the
// unit stops as soon as the remaining bits can no longer change the decision.
//
//   state | meaning
//   IDLE  | ready for a new vector (in_ready=1)
//   ACCUM | adding one chunk popcount per cycle, LSB chunk first
//   DONE  | result held on y/hw/early until the consumer takes it
module folded_threshold_unit #(
  parameter int N          = 31,
  parameter int FOLD_W     = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  folded_threshold_unit_if.slave bus
);
  localparam int CW     = $clog2(N + 1);
  localparam int NCHUNK = (N + FOLD_W - 1) / FOLD_W;
  localparam int PADW   = NCHUNK * FOLD_W;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] MAJ_T = CW'(N / 2 + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t        state;
  logic [PADW-1:0] x_q;
  logic [CW-1:0] t_q;
  logic [CW-1:0] count_q;
  logic [IW-1:0] idx_q;
  logic [1:0]    rst_sync_q;
  logic          rst_sync;
  logic          in_ready_q, out_valid_q, y_q, early_q;
  logic [CW-1:0] hw_q;

  logic [FOLD_W-1:0] chunk;
  logic [CW-1:0]     chunk_ones;
  logic [CW-1:0]     count_next;
  logic [CW:0]       rem;
  logic              last_chunk, hit, miss;
  int                done_bits;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.hw        = hw_q;
  assign bus.early     = early_q;

  // Reset asserts immediately but is released only after two clean clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_sync = rst_sync_q[1];

  // Popcount of the current chunk and the early-decision tests on the updated count.
  always_comb begin
    chunk      = x_q[int'(idx_q) * FOLD_W +: FOLD_W];
    chunk_ones = '0;
    for (int i = 0; i < FOLD_W; i++) chunk_ones = chunk_ones + CW'(chunk[i]);
    count_next = count_q + chunk_ones;
    last_chunk = (idx_q == IW'(NCHUNK - 1));
    done_bits  = (int'(idx_q) + 1) * FOLD_W;
    rem        = (done_bits >= N) ? '0 : (CW + 1)'(N - done_bits);
    hit        = (count_next >= t_q);
    miss       = (({1'b0, count_next} + rem) < {1'b0, t_q});
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      y_q         <= 1'b0;
      hw_q        <= '0;
      early_q     <= 1'b0;
      x_q         <= '0;
      t_q         <= '0;
      count_q     <= '0;
      idx_q       <= '0;
    end else if (!rst_sync) begin
      // Hold off new vectors until the released reset has been synchronised.
      state       <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            x_q        <= PADW'(bus.x);
            t_q        <= bus.thr_mode ? bus.thr : MAJ_T;
            count_q    <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state      <= ACCUM;
          end
        end
        ACCUM: begin
          count_q <= count_next;
          idx_q   <= idx_q + 1'b1;
          if (last_chunk) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            y_q         <= hit;
            hw_q        <= count_next;
            early_q     <= 1'b0;
          end else if (EARLY_EXIT && (hit || miss)) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            y_q         <= hit;
            hw_q        <= count_next;
            early_q     <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_folded_threshold_unit.sv
// Directed bench for folded_threshold_unit over four configurations sharing one
// stimulus bus; sel picks which instance is driven and observed.
module tb_folded_threshold_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int          sel = 0;
  logic        valid_s = 1'b0;
  logic [31:0] x_s = '0;
  logic        mode_s = 1'b0;
  logic [5:0]  thr_s = '0;
  logic        out_ready_s = 1'b1;

  int n_checks = 0;
  int n_fail = 0;

  folded_threshold_unit_if #(.N(31)) if0 ();
  folded_threshold_unit_if #(.N(31)) if1 ();
  folded_threshold_unit_if #(.N(8))  if2 ();
  folded_threshold_unit_if #(.N(1))  if3 ();

  folded_threshold_unit #(.N(31), .FOLD_W(8), .EARLY_EXIT(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  folded_threshold_unit #(.N(31), .FOLD_W(8), .EARLY_EXIT(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  folded_threshold_unit #(.N(8),  .FOLD_W(3), .EARLY_EXIT(1'b1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  folded_threshold_unit #(.N(1),  .FOLD_W(1), .EARLY_EXIT(1'b0)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  assign if0.in_valid = valid_s && (sel == 0);
  assign if1.in_valid = valid_s && (sel == 1);
  assign if2.in_valid = valid_s && (sel == 2);
  assign if3.in_valid = valid_s && (sel == 3);
  assign if0.x = x_s[30:0];
  assign if1.x = x_s[30:0];
  assign if2.x = x_s[7:0];
  assign if3.x = x_s[0];
  assign if0.thr = thr_s[4:0];
  assign if1.thr = thr_s[4:0];
  assign if2.thr = thr_s[3:0];
  assign if3.thr = thr_s[0];
  assign if0.thr_mode = mode_s;
  assign if1.thr_mode = mode_s;
  assign if2.thr_mode = mode_s;
  assign if3.thr_mode = mode_s;
  assign if0.out_ready = out_ready_s;
  assign if1.out_ready = out_ready_s;
  assign if2.out_ready = out_ready_s;
  assign if3.out_ready = out_ready_s;

  logic       in_ready_m, out_valid_m, y_m, early_m;
  logic [5:0] hw_m;
  always_comb begin
    in_ready_m = if0.in_ready; out_valid_m = if0.out_valid; y_m = if0.y;
    early_m = if0.early; hw_m = 6'(if0.hw);
    case (sel)
      1: begin in_ready_m = if1.in_ready; out_valid_m = if1.out_valid; y_m = if1.y; early_m = if1.early; hw_m = 6'(if1.hw); end
      2: begin in_ready_m = if2.in_ready; out_valid_m = if2.out_valid; y_m = if2.y; early_m = if2.early; hw_m = 6'(if2.hw); end
      3: begin in_ready_m = if3.in_ready; out_valid_m = if3.out_valid; y_m = if3.y; early_m = if3.early; hw_m = 6'(if3.hw); end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int popcount(input logic [31:0] v);
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic send(input int s, input logic [31:0] xv, input logic m, input logic [5:0] t);
    int n = 0;
    @(negedge clk);
    sel = s; x_s = xv; mode_s = m; thr_s = t; valid_s = 1'b1;
    #1;
    while (!in_ready_m && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 valid_s = 1'b0;
  endtask

  task automatic get_result(output logic yv, output int hwv, output logic ev, output int lat);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!out_valid_m && lat < 40);
    if (!out_valid_m) chk("result_timeout", 0, 1);
    yv = y_m; hwv = int'(hw_m); ev = early_m;
  endtask

  // One full transaction with hand-computed expectations; exp_hw < 0 skips hw.
  task automatic xact(input string tag, input int s, input logic [31:0] xv, input logic m,
                      input logic [5:0] t, input int ey, input int ehw, input int ee, input int elat);
    logic yv, ev; int hwv, lat;
    send(s, xv, m, t);
    get_result(yv, hwv, ev, lat);
    chk({tag, ".y"}, int'(yv), ey);
    if (ehw >= 0) chk({tag, ".hw"}, hwv, ehw);
    chk({tag, ".early"}, int'(ev), ee);
    chk({tag, ".lat"}, lat, elat);
    @(posedge clk); #1;
    chk({tag, ".in_ready_after"}, int'(in_ready_m), 1);
  endtask

  int n_of[4]   = '{31, 31, 8, 1};
  int nch_of[4] = '{4, 4, 3, 1};
  int cw_of[4]  = '{5, 5, 4, 1};
  int ee_of[4]  = '{0, 1, 1, 0};

  initial begin
    logic yv, ev; int hwv, lat;
    logic [31:0] mask, xv; logic m; int t, texp;

    repeat (3) @(negedge clk);
    sel = 0; #1;
    chk("rst.in_ready", int'(in_ready_m), 1);
    chk("rst.out_valid", int'(out_valid_m), 0);
    chk("rst.y", int'(y_m), 0);
    chk("rst.hw", int'(hw_m), 0);
    chk("rst.early", int'(early_m), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Full-length counting, majority threshold.
    xact("maj16", 0, 32'h0000FFFF, 1'b0, 6'd0, 1, 16, 0, 4);
    xact("maj15", 0, 32'h00007FFF, 1'b0, 6'd0, 0, 15, 0, 4);
    // Early exit on a decided majority.
    xact("ee_ones", 1, 32'h7FFFFFFF, 1'b0, 6'd0, 1, 16, 1, 2);
    xact("ee_zero", 1, 32'h00000000, 1'b0, 6'd0, 0, 0, 1, 2);
    // Programmable threshold, boundaries around popcount=13.
    xact("thr0",  0, 32'h12345678, 1'b1, 6'd0,  1, 13, 0, 4);
    xact("thr13", 0, 32'h12345678, 1'b1, 6'd13, 1, 13, 0, 4);
    xact("thr14", 0, 32'h12345678, 1'b1, 6'd14, 0, 13, 0, 4);
    xact("thr31", 0, 32'h12345678, 1'b1, 6'd31, 0, 13, 0, 4);
    xact("thr31_all", 0, 32'h7FFFFFFF, 1'b1, 6'd31, 1, 31, 0, 4);
    xact("ee_thr31", 1, 32'h12345678, 1'b1, 6'd31, 0, 4, 1, 1);
    xact("ee_thr0",  1, 32'h12345678, 1'b1, 6'd0,  1, 4, 1, 1);
    // Even N: tie is not a majority; threshold above N exits after chunk 0.
    xact("n8_tie",  2, 32'h0000000F, 1'b0, 6'd0, 0, 4, 0, 3);
    xact("n8_maj",  2, 32'h0000001F, 1'b0, 6'd0, 1, 5, 1, 2);
    xact("n8_thr9", 2, 32'h000000FF, 1'b1, 6'd9, 0, 3, 1, 1);
    // Single-bit unit, FOLD_W = N gives one-cycle latency.
    xact("n1_one",  3, 32'h1, 1'b0, 6'd0, 1, 1, 0, 1);
    xact("n1_zero", 3, 32'h0, 1'b0, 6'd0, 0, 0, 0, 1);
    xact("n1_thr0", 3, 32'h0, 1'b1, 6'd0, 1, 0, 0, 1);

    // Backpressure in DONE.
    out_ready_s = 1'b0;
    send(0, 32'h0000FFFF, 1'b0, 6'd0);
    get_result(yv, hwv, ev, lat);
    chk("bp.lat", lat, 4);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp.y", int'(y_m), 1);
      chk("bp.hw", int'(hw_m), 16);
      chk("bp.early", int'(early_m), 0);
      chk("bp.out_valid", int'(out_valid_m), 1);
      chk("bp.in_ready", int'(in_ready_m), 0);
    end
    @(negedge clk) out_ready_s = 1'b1;
    @(posedge clk); #1;
    chk("bp.release_in_ready", int'(in_ready_m), 1);
    chk("bp.release_out_valid", int'(out_valid_m), 0);

    // Reset during the second ACCUM cycle.
    send(0, 32'h0000FFFF, 1'b0, 6'd0);
    @(posedge clk); #1;
    chk("mid.busy", int'(in_ready_m), 0);
    rst_n = 1'b0;
    #1;
    chk("mid.rst_in_ready", int'(in_ready_m), 1);
    chk("mid.rst_out_valid", int'(out_valid_m), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    xact("post_rst", 0, 32'h0000FFFF, 1'b0, 6'd0, 1, 16, 0, 4);

    // Randomised sweep against a popcount reference.
    for (int s = 0; s < 4; s++) begin
      mask = (32'h1 << n_of[s]) - 32'h1;
      for (int k = 0; k < 60; k++) begin
        xv = $urandom & mask;
        if (k % 3 == 0) xv = xv | ($urandom & $urandom & mask);
        m = 1'($urandom_range(0, 1));
        t = int'($urandom_range(0, (1 << cw_of[s]) - 1));
        texp = m ? t : (n_of[s] / 2 + 1);
        send(s, xv, m, 6'(t));
        get_result(yv, hwv, ev, lat);
        chk("rnd.y", int'(yv), (popcount(xv) >= texp) ? 1 : 0);
        if (ee_of[s] == 0) chk("rnd.early", int'(ev), 0);
        if (!ev) begin
          chk("rnd.hw", hwv, popcount(xv));
          chk("rnd.lat", lat, nch_of[s]);
        end else begin
          chk("rnd.lat_early", (lat >= 1 && lat < nch_of[s]) ? 1 : 0, 1);
        end
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
